// File: rtl/ex_issue.sv
// Single-issue execute stage: decodes one RV32 ALU/mul instruction, drives an external ALU
// for its fixed latency, then holds the result until the consumer takes it.
// Build option: define EX_FPADD_EN to accept the fpadd encoding (opcode 1010011, funct7 0000000).
module ex_issue (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_rs1_val,
  input  logic [31:0] in_rs2_val,
  input  logic [4:0]  in_rd,
  output logic [3:0]  alu_control,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  input  logic [31:0] alu_result,
  input  logic        zero_flag,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_zero,
  output logic [4:0]  out_rd,
  output logic        out_illegal,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MUL    = 7'b0000001;
  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SLL   = 4'b0011;
  localparam logic [3:0] ALU_SUB   = 4'b0100;
  localparam logic [3:0] ALU_SRL   = 4'b0101;
  localparam logic [3:0] ALU_MUL   = 4'b0110;
  localparam logic [3:0] ALU_XOR   = 4'b0111;
  localparam logic [3:0] ALU_SLT   = 4'b1000;
  localparam logic [2:0] LAT_ALU   = 3'd1;
  localparam logic [2:0] LAT_MUL   = 3'd3;
`ifdef EX_FPADD_EN
  localparam logic [6:0] OP_FP     = 7'b1010011;
  localparam logic [3:0] ALU_FPADD = 4'b1001;
  localparam logic [2:0] LAT_FPADD = 3'd4;
`endif

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] in1_q, in1_d, in2_q, in2_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] res_q, res_d;
  logic        zero_q, zero_d;
  logic [4:0]  out_rd_q, out_rd_d;
  logic        ill_q, ill_d;

  logic        accept;
  logic        is_r, is_i, base_ok;
  logic [3:0]  dec_ctrl;
  logic [2:0]  dec_lat;
  logic        dec_legal, dec_shift;

  assign is_r    = (in_opcode == OP_R);
  assign is_i    = (in_opcode == OP_I);
  // Immediates occupy funct7 on I-type, so only R-type must carry the base funct7.
  assign base_ok = is_i || (in_funct7 == F7_BASE);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    dec_ctrl  = ALU_AND;
    dec_lat   = LAT_ALU;
    dec_legal = 1'b0;
    dec_shift = 1'b0;
    if (is_r || is_i) begin
      case (in_funct3)
        3'b000: begin
          if (base_ok) begin
            dec_ctrl  = ALU_ADD;
            dec_legal = 1'b1;
          end else if (in_funct7 == F7_ALT) begin
            dec_ctrl  = ALU_SUB;
            dec_legal = 1'b1;
          end else if (in_funct7 == F7_MUL) begin
            dec_ctrl  = ALU_MUL;
            dec_lat   = LAT_MUL;
            dec_legal = 1'b1;
          end
        end
        3'b001: begin
          dec_ctrl  = ALU_SLL;
          dec_shift = 1'b1;
          dec_legal = (in_funct7 == F7_BASE);
        end
        3'b101: begin
          dec_ctrl  = ALU_SRL;
          dec_shift = 1'b1;
          dec_legal = (in_funct7 == F7_BASE);
        end
        3'b010: begin
          dec_ctrl  = ALU_SLT;
          dec_legal = base_ok;
        end
        3'b100: begin
          dec_ctrl  = ALU_XOR;
          dec_legal = base_ok;
        end
        3'b110: begin
          dec_ctrl  = ALU_OR;
          dec_legal = base_ok;
        end
        3'b111: begin
          dec_ctrl  = ALU_AND;
          dec_legal = base_ok;
        end
      endcase
    end
`ifdef EX_FPADD_EN
    if (in_opcode == OP_FP && in_funct7 == F7_BASE) begin
      dec_ctrl  = ALU_FPADD;
      dec_lat   = LAT_FPADD;
      dec_legal = 1'b1;
    end
`endif
  end

  assign accept = in_valid && in_ready;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = dec_legal ? EXEC : DONE;
      EXEC:    if (cnt_q == 3'd1) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = reset_n && (state_q == IDLE);
    busy      = (state_q != IDLE);
    out_valid = (state_q == DONE);
  end

  always_comb begin
    cnt_d    = cnt_q;
    ctrl_d   = ctrl_q;
    in1_d    = in1_q;
    in2_d    = in2_q;
    rd_d     = rd_q;
    res_d    = res_q;
    zero_d   = zero_q;
    out_rd_d = out_rd_q;
    ill_d    = ill_q;
    if (accept) begin
      ctrl_d = dec_legal ? dec_ctrl : ALU_AND;
      in1_d  = in_rs1_val;
      in2_d  = dec_shift ? {27'b0, in_rs2_val[4:0]} : in_rs2_val;
      cnt_d  = dec_legal ? dec_lat : 3'd0;
      rd_d   = in_rd;
      if (!dec_legal) begin
        res_d    = '0;
        zero_d   = 1'b1;
        ill_d    = 1'b1;
        out_rd_d = in_rd;
      end
    end else if (state_q == EXEC) begin
      cnt_d = cnt_q - 3'd1;
      if (cnt_q == 3'd1) begin
        res_d    = alu_result;
        zero_d   = zero_flag;
        out_rd_d = rd_q;
        ill_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      ctrl_q   <= '0;
      in1_q    <= '0;
      in2_q    <= '0;
      rd_q     <= '0;
      res_q    <= '0;
      zero_q   <= 1'b0;
      out_rd_q <= '0;
      ill_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      ctrl_q   <= ctrl_d;
      in1_q    <= in1_d;
      in2_q    <= in2_d;
      rd_q     <= rd_d;
      res_q    <= res_d;
      zero_q   <= zero_d;
      out_rd_q <= out_rd_d;
      ill_q    <= ill_d;
    end
  end

  assign alu_control = ctrl_q;
  assign alu_in1     = in1_q;
  assign alu_in2     = in2_q;
  assign out_result  = res_q;
  assign out_zero    = zero_q;
  assign out_rd      = out_rd_q;
  assign out_illegal = ill_q;

endmodule
